// File: rtl/dfdd_pkg.sv
// Shared types and constants for the pixel coordinate tagging stage
// that feeds the radial a/b zone lookup.
package dfdd_pkg;

  localparam int unsigned COORD_W    = 16;
  localparam int unsigned PIX_DATA_W = 16;
  localparam int unsigned ERR_W      = 2;

  localparam int unsigned ERR_EARLY_SOF = 0;
  localparam int unsigned ERR_NO_SOF    = 1;

  typedef struct packed {
    logic [PIX_DATA_W-1:0] data;
    logic [COORD_W-1:0]    col;
    logic [COORD_W-1:0]    row;
    logic                  eol;
    logic                  eof;
  } pix_tag_t;

  localparam int unsigned PIX_TAG_W = $bits(pix_tag_t);

  typedef enum logic {
    ST_WAIT_SOF = 1'b0,
    ST_IN_FRAME = 1'b1
  } frm_state_t;

endpackage

// File: rtl/stream_skid_buffer.sv
// Registered valid/ready stage with a one-entry skid register; ready is
// a flop, so the downstream ready never reaches the upstream ready.
module stream_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             w_in_fire;
  logic             w_out_free;

  assign w_in_fire  = in_valid_i & r_in_ready;
  assign w_out_free = ~r_out_valid | out_ready_i;

  // r_in_ready low means the skid register holds a beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_data  <= '0;
      r_skid_data <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (w_out_free) begin
      if (!r_in_ready) begin
        r_out_data  <= r_skid_data;
        r_out_valid <= 1'b1;
        r_in_ready  <= 1'b1;
      end else if (w_in_fire) begin
        r_out_data  <= in_data_i;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_data <= in_data_i;
      r_in_ready  <= 1'b0;
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_data_o  = r_out_data;
  assign out_valid_o = r_out_valid;

endmodule

// File: rtl/pixel_coord_tagger.sv
// Tags a raster pixel stream with column/row coordinates and end-of-line/
// end-of-frame flags, with sticky framing-error reporting.
module pixel_coord_tagger
  import dfdd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned IMAGE_WIDTH  = 640,
  parameter int unsigned IMAGE_HEIGHT = 480
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  sof_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [COORD_W-1:0]    col_o,
  output logic [COORD_W-1:0]    row_o,
  output logic                  eol_o,
  output logic                  eof_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic                  clear_err_i,
  output logic [ERR_W-1:0]      err_o
);

  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMAGE_WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMAGE_HEIGHT - 1);

  frm_state_t             r_state;
  frm_state_t             w_state_nxt;
  logic [COORD_W-1:0]     r_col_cnt;
  logic [COORD_W-1:0]     r_row_cnt;
  logic [COORD_W-1:0]     w_col_tag;
  logic [COORD_W-1:0]     w_row_tag;
  logic                   w_eol;
  logic                   w_eof;
  logic                   w_ready;
  logic                   w_in_hs;
  logic                   w_fwd;
  logic                   w_accept;
  logic                   w_cnt_zero;
  logic [ERR_W-1:0]       r_err;
  logic [ERR_W-1:0]       w_err_set;
  pix_tag_t               w_in_tag;
  pix_tag_t               w_out_tag;
  logic [PIX_TAG_W-1:0]   w_out_bits;
  logic                   w_out_valid;

  assign w_in_hs    = valid_i & w_ready;
  assign w_fwd      = (r_state == ST_IN_FRAME) | sof_i;
  assign w_accept   = w_in_hs & w_fwd;
  assign w_cnt_zero = (r_col_cnt == '0) & (r_row_cnt == '0);

  // sof forces the (0,0) tag whatever the counters say.
  assign w_col_tag = sof_i ? '0 : r_col_cnt;
  assign w_row_tag = sof_i ? '0 : r_row_cnt;
  assign w_eol     = (w_col_tag == LAST_COL);
  assign w_eof     = w_eol & (w_row_tag == LAST_ROW);

  assign w_in_tag = '{
    data: PIX_DATA_W'(data_i),
    col:  w_col_tag,
    row:  w_row_tag,
    eol:  w_eol,
    eof:  w_eof
  };

  // Counters sit at (0,0) in frame only right after eof, since a line
  // holds at least two pixels.
  always_comb begin
    w_err_set                = '0;
    w_err_set[ERR_EARLY_SOF] = w_in_hs & sof_i & ~w_cnt_zero;
    w_err_set[ERR_NO_SOF]    = w_in_hs & ~sof_i &
                               ((r_state == ST_WAIT_SOF) | w_cnt_zero);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_WAIT_SOF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT_SOF: if (w_in_hs && sof_i) w_state_nxt = ST_IN_FRAME;
      ST_IN_FRAME: w_state_nxt = ST_IN_FRAME;
      default:     w_state_nxt = ST_WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else if (w_accept) begin
      if (w_eol) begin
        r_col_cnt <= '0;
        r_row_cnt <= w_eof ? '0 : w_row_tag + COORD_W'(1);
      end else begin
        r_col_cnt <= w_col_tag + COORD_W'(1);
        r_row_cnt <= w_row_tag;
      end
    end
  end

  // A new error event overrides a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= '0;
    end else begin
      r_err <= (clear_err_i ? '0 : r_err) | w_err_set;
    end
  end

  stream_skid_buffer #(
    .WIDTH(PIX_TAG_W)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_data_i  (w_in_tag),
    .in_valid_i (valid_i & w_fwd),
    .in_ready_o (w_ready),
    .out_data_o (w_out_bits),
    .out_valid_o(w_out_valid),
    .out_ready_i(ready_i)
  );

  assign w_out_tag = pix_tag_t'(w_out_bits);

  assign ready_o = w_ready;
  assign valid_o = w_out_valid;
  assign data_o  = DATA_WIDTH'(w_out_tag.data);
  assign col_o   = w_out_tag.col;
  assign row_o   = w_out_tag.row;
  assign eol_o   = w_out_tag.eol;
  assign eof_o   = w_out_tag.eof;
  assign err_o   = r_err;

endmodule

// File: tb/tb_pixel_coord_tagger.sv
// Randomized self-checking bench for pixel_coord_tagger on a 4x3 image,
// checked against a linear-pixel-index reference model.
module tb_pixel_coord_tagger;

  localparam int W = 4;
  localparam int H = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] data_i = '0;
  logic        sof_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [15:0] data_o;
  logic [15:0] col_o;
  logic [15:0] row_o;
  logic        eol_o;
  logic        eof_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        clear_err_i = 1'b0;
  logic [1:0]  err_o;

  always #5 clk_i = ~clk_i;

  pixel_coord_tagger #(
    .DATA_WIDTH  (16),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .sof_i      (sof_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .col_o      (col_o),
    .row_o      (row_o),
    .eol_o      (eol_o),
    .eof_o      (eof_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .clear_err_i(clear_err_i),
    .err_o      (err_o)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] col;
    logic [15:0] row;
    logic        eol;
    logic        eof;
  } beat_t;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
  } px_t;

  px_t   tx_q[$];
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    exp_cyc[$];
  int    obs_cyc[$];

  int       m_pos;
  bit       m_in_frame;
  logic [1:0] m_err;

  int n_checks = 0;
  int n_errors = 0;
  int stall_viol;
  int rdy_viol;
  bit timed_out;

  // Reference: position is a linear index into the frame.
  task automatic model_accept(input logic [15:0] d, input logic s, input int cyc,
                              output bit fwd);
    beat_t b;
    int c, r;
    fwd = 1'b0;
    if (!m_in_frame && !s) begin
      m_err[1] = 1'b1;
      return;
    end
    if (s) begin
      if (m_pos != 0) m_err[0] = 1'b1;
      m_pos      = 0;
      m_in_frame = 1'b1;
    end else if (m_pos == 0) begin
      m_err[1] = 1'b1;
    end
    c      = m_pos % W;
    r      = m_pos / W;
    b.data = d;
    b.col  = 16'(c);
    b.row  = 16'(r);
    b.eol  = (c == W - 1);
    b.eof  = (m_pos == W * H - 1);
    exp_q.push_back(b);
    exp_cyc.push_back(cyc);
    m_pos = (m_pos + 1) % (W * H);
    fwd   = 1'b1;
  endtask

  task automatic add_pixels(input int n, input int sof_a, input int sof_b);
    px_t p;
    for (int i = 0; i < n; i++) begin
      p.data = 16'($urandom);
      p.sof  = (i == sof_a) || (i == sof_b);
      tx_q.push_back(p);
    end
  endtask

  task automatic clear_model();
    tx_q.delete();
    exp_q.delete();
    obs_q.delete();
    exp_cyc.delete();
    obs_cyc.delete();
    m_pos      = 0;
    m_in_frame = 1'b0;
    m_err      = 2'b00;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    valid_i     = 1'b0;
    sof_i       = 1'b0;
    ready_i     = 1'b0;
    clear_err_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    clear_model();
  endtask

  // mode 0: ready high; 1: ready toggles plus 3-cycle stall at pixel 5;
  // 2: random valid and ready. Records observed beats and violations.
  task automatic run(input int mode);
    int    idx = 0, inflight = 0, cyc = 0, stall_left = 0;
    bit    stall_done = 0, prev_stall = 0, toggle = 0, fwd;
    beat_t snap = '0, cur;
    stall_viol = 0;
    rdy_viol   = 0;
    timed_out  = 1'b0;
    while (idx < tx_q.size() || inflight > 0) begin
      if (cyc >= 600) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk_i);
      if (idx < tx_q.size()) begin
        valid_i = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        data_i  = tx_q[idx].data;
        sof_i   = tx_q[idx].sof;
      end else begin
        valid_i = 1'b0;
        sof_i   = 1'b0;
      end
      case (mode)
        0: ready_i = 1'b1;
        1: begin
          if (idx == 5 && !stall_done) begin
            stall_left = 3;
            stall_done = 1'b1;
          end
          if (stall_left > 0) begin
            ready_i = 1'b0;
            stall_left--;
          end else begin
            toggle  = !toggle;
            ready_i = toggle;
          end
        end
        default: ready_i = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      cur = {data_o, col_o, row_o, eol_o, eof_o};
      if (prev_stall && cur !== snap) stall_viol++;
      if (ready_o !== 1'(inflight < 2)) rdy_viol++;
      if (valid_o && ready_i) begin
        obs_q.push_back(cur);
        obs_cyc.push_back(cyc);
        inflight--;
      end
      if (valid_i && ready_o) begin
        model_accept(data_i, sof_i, cyc, fwd);
        idx++;
        if (fwd) inflight++;
      end
      prev_stall = valid_o && !ready_i;
      snap       = cur;
      cyc++;
    end
    valid_i = 1'b0;
    sof_i   = 1'b0;
    ready_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_handshake valid_o=%b ready_o=%b exp 0/1", valid_o, ready_o);
    end
    n_checks++;
    if (err_o !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_err got %b exp 00", err_o);
    end
    n_checks++;
    if ({data_o, col_o, row_o, eol_o, eof_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_payload got %h/%0d/%0d/%b/%b exp zeros",
               data_o, col_o, row_o, eol_o, eof_o);
    end
  endtask

  task automatic test_basic_frame();
    do_reset();
    add_pixels(12, 0, -1);
    run(0);
    n_checks++;
    if (timed_out !== 1'b0 || obs_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL basic_count got %0d exp %0d timeout=%b", obs_q.size(), exp_q.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL basic_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
      n_checks++;
      if (obs_cyc[i] != exp_cyc[i] + 1) begin
        n_errors++;
        $display("FAIL basic_latency%0d got cycle %0d exp %0d", i, obs_cyc[i], exp_cyc[i] + 1);
      end
    end
    n_checks++;
    if (err_o !== 2'b00) begin
      n_errors++;
      $display("FAIL basic_err got %b exp 00", err_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    add_pixels(12, 0, -1);
    run(1);
    n_checks++;
    if (timed_out !== 1'b0 || obs_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL bp_count got %0d exp %0d timeout=%b", obs_q.size(), exp_q.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL bp_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (stall_viol != 0) begin
      n_errors++;
      $display("FAIL bp_stable got %0d changes while stalled exp 0", stall_viol);
    end
    n_checks++;
    if (rdy_viol != 0) begin
      n_errors++;
      $display("FAIL bp_ready got %0d cycles ready_o != !skid_full exp 0", rdy_viol);
    end
    n_checks++;
    if (err_o !== 2'b00) begin
      n_errors++;
      $display("FAIL bp_err got %b exp 00", err_o);
    end
  endtask

  task automatic test_missing_sof_after_reset();
    do_reset();
    add_pixels(3, -1, -1);
    add_pixels(12, 0, -1);
    run(0);
    n_checks++;
    if (timed_out !== 1'b0 || obs_q.size() != 12) begin
      n_errors++;
      $display("FAIL nosof_count got %0d exp 12 timeout=%b", obs_q.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL nosof_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (obs_q.size() == 0 || obs_q[0].col !== 16'd0 || obs_q[0].row !== 16'd0 ||
        obs_q[0].data !== tx_q[3].data) begin
      n_errors++;
      $display("FAIL nosof_first got %h exp data %h at (0,0)",
               (obs_q.size() != 0) ? obs_q[0] : beat_t'('0), tx_q[3].data);
    end
    n_checks++;
    if (err_o !== 2'b10) begin
      n_errors++;
      $display("FAIL nosof_err got %b exp 10", err_o);
    end
  endtask

  task automatic test_early_sof();
    do_reset();
    add_pixels(12, 0, 6);
    run(2);
    n_checks++;
    if (timed_out !== 1'b0 || obs_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL early_count got %0d exp %0d timeout=%b", obs_q.size(), exp_q.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL early_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (err_o !== m_err || err_o !== 2'b01) begin
      n_errors++;
      $display("FAIL early_err got %b exp 01 (model %b)", err_o, m_err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    add_pixels(12, 0, -1);
    add_pixels(12, -1, -1);
    run(2);
    n_checks++;
    if (timed_out !== 1'b0 || obs_q.size() != 24) begin
      n_errors++;
      $display("FAIL b2b_count got %0d exp 24 timeout=%b", obs_q.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL b2b_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (err_o !== m_err || err_o !== 2'b10) begin
      n_errors++;
      $display("FAIL b2b_err got %b exp 10 (model %b)", err_o, m_err);
    end
    @(negedge clk_i);
    clear_err_i = 1'b1;
    @(negedge clk_i);
    clear_err_i = 1'b0;
    m_err       = 2'b00;
    #1;
    n_checks++;
    if (err_o !== m_err) begin
      n_errors++;
      $display("FAIL b2b_clear got %b exp 00", err_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    @(negedge clk_i);
    ready_i = 1'b0;
    valid_i = 1'b1;
    sof_i   = 1'b1;
    data_i  = 16'h1111;
    @(negedge clk_i);
    sof_i  = 1'b0;
    data_i = 16'h2222;
    @(negedge clk_i);
    valid_i = 1'b0;
    #1;
    n_checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_full ready_o=%b valid_o=%b exp 0/1", ready_o, valid_o);
    end
    #1 rst_i = 1'b1;
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_async valid_o=%b ready_o=%b exp 0/1", valid_o, ready_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_model();
    add_pixels(12, 0, -1);
    run(0);
    n_checks++;
    if (timed_out !== 1'b0 || obs_q.size() != 12) begin
      n_errors++;
      $display("FAIL midrst_count got %0d exp 12 timeout=%b", obs_q.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL midrst_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (err_o !== 2'b00) begin
      n_errors++;
      $display("FAIL midrst_err got %b exp 00", err_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_missing_sof_after_reset();
    test_early_sof();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
